// File: rtl/song_recorder_if.sv
// song_recorder_if
//   Bundles the recorder's control inputs and its song-buffer outputs.
//   The master modport drives the controls (keyboard/front panel side).
//   The slave modport is the recorder itself.
//
//   rec_start  start pulse for a new recording
//   rec_stop   stop pulse that ends the recording
//   touch      key switches; touch[7] = do ... touch[1] = si, touch[0] unused
//   octave     00 low, 01 mid, 10 high, 11 mid
//   song       packed 5-bit note codes; slot i = song[i*5+4 -: 5]
//   beat       packed 2-bit beat codes; slot i = beat[i*2+1 -: 2]
//   length     number of valid slots
//   recording  high while a recording is in progress
//   full       high when length == MAX_NOTES
//   done       one-cycle pulse when a recording finishes
interface song_recorder_if #(
  parameter int MAX_NOTES = 64
);
  logic                   rec_start;
  logic                   rec_stop;
  logic [7:0]             touch;
  logic [1:0]             octave;
  logic [MAX_NOTES*5-1:0] song;
  logic [MAX_NOTES*2-1:0] beat;
  logic [7:0]             length;
  logic                   recording;
  logic                   full;
  logic                   done;

  modport master (
    output rec_start, rec_stop, touch, octave,
    input  song, beat, length, recording, full, done
  );

  modport slave (
    input  rec_start, rec_stop, touch, octave,
    output song, beat, length, recording, full, done
  );
endinterface

// File: rtl/song_recorder.sv
// song_recorder
//   Captures live keyboard play and writes it into the packed song/beat
//   buffer format consumed by the playback and learning modes. Each slot
//   holds a 5-bit note code (0 = rest) and a 2-bit quantised beat code.
//
//   Optional feature macro: SONG_RECORDER_RESTS_EN
//     defined   - silences of two or more ticks between notes are stored
//                 as rest slots (code 0) with a quantised beat
//     undefined - silences are dropped; only notes are stored
//
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset; aborts to IDLE, clears buffer
//     bus  song_recorder_if.slave (controls in, song buffer and status out)
//
//   Parameters:
//     MAX_NOTES  slot count of the buffer (up to 255)
//     TICK_DIV   clk cycles per beat tick
module song_recorder #(
  parameter int MAX_NOTES = 64,
  parameter int TICK_DIV  = 6000
) (
  input logic            clk,
  input logic            rst,
  song_recorder_if.slave bus
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       MAX_LEN  = 8'(MAX_NOTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_NOTE,
`ifdef SONG_RECORDER_RESTS_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  // Note code from key number (1..7) and octave; 11 falls back to mid.
  function automatic logic [4:0] note_code(input logic [2:0] key, input logic [1:0] oct);
    logic [4:0] code;
    case (oct)
      2'b00:   code = {2'b00, key};
      2'b10:   code = {2'b00, key} + 5'd14;
      default: code = {2'b00, key} + 5'd7;
    endcase
    return code;
  endfunction

  // Duration in ticks to beat code, matching player lengths 2/3/4/5.
  function automatic logic [1:0] beat_quant(input logic [2:0] d);
    logic [1:0] b;
    if (d <= 3'd2)      b = 2'b00;
    else if (d == 3'd3) b = 2'b01;
    else if (d == 3'd4) b = 2'b10;
    else                b = 2'b11;
    return b;
  endfunction

  // 3-bit tick counter increment, saturating at 7.
  function automatic logic [2:0] dur_sat_inc(input logic [2:0] d, input logic t);
    logic [2:0] r;
    r = d;
    if (t && (d != 3'd7)) r = d + 3'd1;
    return r;
  endfunction

  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       tick_cnt;
  logic                   tick;
  logic [7:0]             touch_keys;
  logic                   key_valid;
  logic [2:0]             key_num;
  logic [4:0]             key_code;
  logic [2:0]             cur_key_q;
  logic [4:0]             cur_code_q;
  logic [2:0]             dur_q;
  logic [2:0]             dur_eff;
  logic [7:0]             len_q;
  logic                   full_q;
  logic [MAX_NOTES*5-1:0] song_q;
  logic [MAX_NOTES*2-1:0] beat_q;
  logic                   recording_q;
  logic                   done_q;
  logic                   rec_n;

  logic                   start_clr;
  logic                   commit;
  logic [4:0]             commit_code;
  logic [1:0]             commit_beat;
  logic                   latch;
  logic                   dur_clr;
  logic                   dur_cnt;

  // Beat-tick prescaler, restarted when a recording begins so that the
  // first tick lands a full period after rec_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (start_clr || (tick_cnt == CNT_LAST)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == CNT_LAST);

  // Key decode: only a single pressed key among touch[7:1] is a note.
  always_comb begin
    touch_keys = bus.touch & 8'hFE;
    key_valid  = $onehot(touch_keys);
    key_num    = '0;
    for (int i = 1; i < 8; i++) begin
      if (touch_keys[i]) key_num = 3'(8 - i);
    end
  end

  assign key_code = note_code(key_num, bus.octave);

  // A tick arriving in the same cycle as a key event still belongs to the
  // note (or gap) being closed, so commits use the post-tick duration.
  assign dur_eff = dur_sat_inc(dur_q, tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    start_clr   = 1'b0;
    commit      = 1'b0;
    commit_code = cur_code_q;
    commit_beat = beat_quant(dur_eff);
    latch       = 1'b0;
    dur_clr     = 1'b0;
    dur_cnt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rec_start) begin
          start_clr = 1'b1;
          state_n   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rec_stop) begin
          state_n = S_DONE;
        end else if (key_valid) begin
          latch   = 1'b1;
          state_n = S_NOTE;
        end
      end
      S_NOTE: begin
        if (bus.rec_stop) begin
          commit  = 1'b1;
          state_n = S_DONE;
        end else if (!key_valid) begin
          commit  = 1'b1;
`ifdef SONG_RECORDER_RESTS_EN
          dur_clr = 1'b1;
          state_n = S_GAP;
`else
          state_n = S_WAIT;
`endif
        end else if (key_num != cur_key_q) begin
          // Direct slide to another key: close the old note, open the new.
          commit = 1'b1;
          latch  = 1'b1;
        end else begin
          dur_cnt = 1'b1;
        end
      end
`ifdef SONG_RECORDER_RESTS_EN
      S_GAP: begin
        if (bus.rec_stop) begin
          state_n = S_DONE;
        end else if (key_valid) begin
          // Short gaps are articulation, not rests. The length guard keeps
          // slot 0 from ever holding a rest.
          if ((dur_eff >= 3'd2) && (len_q != 8'd0)) begin
            commit      = 1'b1;
            commit_code = 5'd0;
          end
          latch   = 1'b1;
          state_n = S_NOTE;
        end else begin
          dur_cnt = 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rec_n = (state_n == S_WAIT) || (state_n == S_NOTE);
`ifdef SONG_RECORDER_RESTS_EN
    rec_n = rec_n || (state_n == S_GAP);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      full_q      <= 1'b0;
      song_q      <= '0;
      beat_q      <= '0;
      cur_key_q   <= '0;
      cur_code_q  <= '0;
      dur_q       <= '0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (start_clr) begin
        len_q  <= '0;
        full_q <= 1'b0;
        song_q <= '0;
        beat_q <= '0;
      end else if (commit && !full_q) begin
        for (int i = 0; i < MAX_NOTES; i++) begin
          if (len_q == 8'(i)) begin
            song_q[i*5 +: 5] <= commit_code;
            beat_q[i*2 +: 2] <= commit_beat;
          end
        end
        len_q  <= len_q + 8'd1;
        full_q <= ((len_q + 8'd1) == MAX_LEN);
      end

      if (latch) begin
        cur_key_q  <= key_num;
        cur_code_q <= key_code;
      end

      if (start_clr || latch || dur_clr) begin
        dur_q <= '0;
      end else if (dur_cnt) begin
        dur_q <= dur_eff;
      end

      recording_q <= rec_n;
      done_q      <= (state_n == S_DONE);
    end
  end

  assign bus.song      = song_q;
  assign bus.beat      = beat_q;
  assign bus.length    = len_q;
  assign bus.full      = full_q;
  assign bus.recording = recording_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder
//   Directed bench for song_recorder with MAX_NOTES=4, TICK_DIV=4.
//   Single-note recordings come from a vector table; key change, full
//   buffer, rests and mid-note reset are hand-written sequences.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_song_recorder;
  localparam int MAXN = 4;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  song_recorder_if #(.MAX_NOTES(MAXN)) sif();

  song_recorder #(.MAX_NOTES(MAXN), .TICK_DIV(TDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] touch;
    logic [1:0] oct;
    int         ticks;
    int         exp_len;
    logic [4:0] exp_code;
    logic [1:0] exp_beat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] slot_code(input int i);
    return sif.song[i*5 +: 5];
  endfunction

  function automatic logic [1:0] slot_beat(input int i);
    return sif.beat[i*2 +: 2];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_rec();
    sif.rec_start = 1'b1;
    cyc(1);
    sif.rec_start = 1'b0;
  endtask

  // Hold a key for ticks*TDIV+2 cycles so exactly `ticks` beat ticks fall
  // inside the note, then release for `gap` cycles.
  task automatic play(input logic [7:0] t, input logic [1:0] o, input int ticks, input int gap);
    sif.touch  = t;
    sif.octave = o;
    cyc(ticks * TDIV + 2);
    sif.touch = 8'h00;
    cyc(gap);
  endtask

  task automatic stop_rec(output int pulses);
    sif.rec_stop = 1'b1;
    cyc(1);
    sif.rec_stop = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (sif.done === 1'b1) pulses++;
      cyc(1);
    end
  endtask

  initial begin
    int p;
    int seen;

    vecs[0] = '{8'h80, 2'b00, 3, 1, 5'd1,  2'b01};
    vecs[1] = '{8'h02, 2'b10, 4, 1, 5'd21, 2'b10};
    vecs[2] = '{8'h10, 2'b11, 1, 1, 5'd11, 2'b00};
    vecs[3] = '{8'h04, 2'b00, 9, 1, 5'd6,  2'b11};
    vecs[4] = '{8'hC0, 2'b00, 5, 0, 5'd0,  2'b00};
    vecs[5] = '{8'h00, 2'b01, 2, 0, 5'd0,  2'b00};
    vecs[6] = '{8'h08, 2'b01, 5, 1, 5'd12, 2'b11};
    vecs[7] = '{8'h20, 2'b10, 2, 1, 5'd17, 2'b00};

    sif.rec_start = 1'b0;
    sif.rec_stop  = 1'b0;
    sif.touch     = 8'h00;
    sif.octave    = 2'b00;

    // Reset state
    cyc(2);
    chk("rst_length", sif.length, 0);
    chk("rst_song", 32'(sif.song), 0);
    chk("rst_beat", 32'(sif.beat), 0);
    chk("rst_recording", sif.recording, 0);
    chk("rst_full", sif.full, 0);
    chk("rst_done", sif.done, 0);
    rst = 1'b0;
    cyc(2);
    chk("idle_recording", sif.recording, 0);

    // Single-note table
    for (int v = 0; v < 8; v++) begin
      start_rec();
      chk($sformatf("v%0d_recording", v), sif.recording, 1);
      play(vecs[v].touch, vecs[v].oct, vecs[v].ticks, 2);
      stop_rec(p);
      chk($sformatf("v%0d_length", v), sif.length, vecs[v].exp_len);
      chk($sformatf("v%0d_code0", v), slot_code(0), vecs[v].exp_code);
      chk($sformatf("v%0d_beat0", v), slot_beat(0), vecs[v].exp_beat);
      chk($sformatf("v%0d_full", v), sif.full, 0);
      chk($sformatf("v%0d_done_pulses", v), p, 1);
      chk($sformatf("v%0d_rec_after", v), sif.recording, 0);
    end

    // Mid-octave key change with octave moved during the first note
    start_rec();
    sif.touch  = 8'h40;
    sif.octave = 2'b01;
    cyc(10);
    sif.octave = 2'b10;
    cyc(10);
    sif.octave = 2'b01;
    cyc(2);
    sif.touch = 8'h20;
    cyc(8);
    stop_rec(p);
    sif.touch = 8'h00;
    chk("chg_length", sif.length, 2);
    chk("chg_code0", slot_code(0), 9);
    chk("chg_beat0", slot_beat(0), 2'b11);
    chk("chg_code1", slot_code(1), 10);
    chk("chg_beat1", slot_beat(1), 2'b00);
    chk("chg_done_pulses", p, 1);

    // Full buffer: six notes into four slots; stray rec_start ignored
    start_rec();
    for (int k = 0; k < 6; k++) begin
      logic [7:0] key;
      key = 8'h80 >> k;
      sif.touch  = key;
      sif.octave = 2'b00;
      cyc(10);
      sif.touch = 8'h00;
      if (k == 2) begin
        sif.rec_start = 1'b1;
        cyc(1);
        sif.rec_start = 1'b0;
        cyc(1);
      end else begin
        cyc(2);
      end
      chk($sformatf("full_len_%0d", k), sif.length, (k < 3) ? k + 1 : 4);
      chk($sformatf("full_flag_%0d", k), sif.full, (k >= 3) ? 1 : 0);
    end
    stop_rec(p);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("full_code%0d", s), slot_code(s), s + 1);
      chk($sformatf("full_beat%0d", s), slot_beat(s), 0);
    end
    chk("full_done_pulses", p, 1);

    // Rests: lead-in silence, note, 3-tick silence, note
    start_rec();
    cyc(12);
    sif.touch  = 8'h80;
    sif.octave = 2'b00;
    cyc(10);
    sif.touch = 8'h00;
    cyc(12);
    sif.touch  = 8'h04;
    sif.octave = 2'b01;
    cyc(12);
    sif.touch = 8'h00;
    cyc(2);
    stop_rec(p);
    chk("rest_code0", slot_code(0), 1);
    chk("rest_beat0", slot_beat(0), 2'b00);
`ifdef SONG_RECORDER_RESTS_EN
    chk("rest_length", sif.length, 3);
    chk("rest_code1", slot_code(1), 0);
    chk("rest_beat1", slot_beat(1), 2'b01);
    chk("rest_code2", slot_code(2), 13);
    chk("rest_beat2", slot_beat(2), 2'b01);
`else
    chk("rest_length", sif.length, 2);
    chk("rest_code1", slot_code(1), 13);
    chk("rest_beat1", slot_beat(1), 2'b01);
    chk("rest_code2", slot_code(2), 0);
`endif
    chk("rest_done_pulses", p, 1);

    // Reset while a third note is held
    start_rec();
    play(8'h80, 2'b00, 1, 2);
    play(8'h40, 2'b00, 1, 2);
    sif.touch = 8'h20;
    cyc(3);
    chk("rstn_len_before", sif.length, 2);
    chk("rstn_rec_before", sif.recording, 1);
    rst = 1'b1;
    #1;
    chk("rstn_length", sif.length, 0);
    chk("rstn_song", 32'(sif.song), 0);
    chk("rstn_beat", 32'(sif.beat), 0);
    chk("rstn_recording", sif.recording, 0);
    chk("rstn_full", sif.full, 0);
    chk("rstn_done", sif.done, 0);
    cyc(1);
    rst = 1'b0;
    sif.touch = 8'h00;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (sif.done === 1'b1 || sif.recording === 1'b1) seen++;
      cyc(1);
    end
    chk("rstn_quiet", seen, 0);

    // rec_stop in IDLE is ignored
    stop_rec(p);
    chk("idle_stop_done", p, 0);
    chk("idle_stop_len", sif.length, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
